// File: rtl/lfsr_symbol_mapper.sv
// -----------------------------------------------------------------------------
// lfsr_symbol_mapper
//
// Consumer of the 22-bit maximal-length LFSR in the transmit test chain.
// Issues the LFSR seed-load strobe, then samples the LFSR state once per
// symbol period and maps its two LSBs onto a Gray-coded 4-ASK level in signed
// 1s17 format. The LFSR period is measured by counting RUN cycles between
// successive appearances of the seed state.
//
// Optional feature (compile-time macro LFSR_LOCKUP_DET_EN):
//   defined   - an all-zero LFSR state in RUN sets the sticky lockup flag and
//               forces a reseed (RUN -> LOAD), suppressing that cycle's symbol.
//   undefined - lockup is tied low; an all-zero state maps like any other.
//
// Parameters:
//   SPS      samples (clocks) per symbol, 1..16
//   A_LEVEL  inner 4-ASK amplitude in 1s17; outer level is 3*A_LEVEL
//   OUT_W    signed output symbol width
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   start       begins a seed-load and run sequence from IDLE
//   stop        returns to IDLE (wins over start)
//   lfsr_in     22-bit LFSR state
//   lfsr_load   one-cycle seed-load strobe to the LFSR
//   sym_out     signed 4-ASK symbol, held between updates
//   sym_valid   one-cycle pulse when sym_out was updated
//   busy        high in LOAD, SETTLE and RUN
//   seq_wrap    one-cycle pulse when the LFSR returned to its seed
//   period_out  RUN cycles between successive seed occurrences
//   lockup      sticky all-zero-state flag (optional feature only)
// -----------------------------------------------------------------------------
module lfsr_symbol_mapper #(
    parameter int SPS     = 4,
    parameter int A_LEVEL = 32768,
    parameter int OUT_W   = 18
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [21:0]             lfsr_in,
    output logic                    lfsr_load,
    output logic signed [OUT_W-1:0] sym_out,
    output logic                    sym_valid,
    output logic                    busy,
    output logic                    seq_wrap,
    output logic [22:0]             period_out,
    output logic                    lockup
);

    localparam int     PER_W   = 23;
    localparam int     CNT_W   = (SPS > 1) ? $clog2(SPS) : 1;
    localparam longint OUTER   = 3 * longint'(A_LEVEL);
    localparam longint MAX_POS = (longint'(1) << (OUT_W - 1)) - 1;

    // Illegal configurations stop elaboration rather than silently wrapping.
    if (SPS < 1 || SPS > 16) begin : g_bad_sps
        $error("lfsr_symbol_mapper: SPS=%0d outside 1..16", SPS);
    end
    if (A_LEVEL <= 0 || OUTER > MAX_POS) begin : g_bad_level
        $error("lfsr_symbol_mapper: 3*A_LEVEL=%0d does not fit OUT_W=%0d signed",
               OUTER, OUT_W);
    end

    localparam logic signed [OUT_W-1:0] LVL_INNER   = OUT_W'(A_LEVEL);
    localparam logic signed [OUT_W-1:0] LVL_OUTER   = OUT_W'(OUTER);
    localparam logic        [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SPS - 1);
    localparam logic        [PER_W-1:0] CYC_MAX     = '1;
    localparam logic        [PER_W-1:0] CYC_ONE     = PER_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [21:0]        seed_reg;
    logic [CNT_W-1:0]   sample_cnt;
    logic [PER_W-1:0]   cycle_cnt;
    logic               lock_hit;
    logic               seed_hit;
    logic               sample_fire;

    // Gray-coded 4-ASK map: adjacent levels differ in one bit.
    function automatic logic signed [OUT_W-1:0] map_level(input logic [1:0] bits);
        logic signed [OUT_W-1:0] lvl;
        case (bits)
            2'b00:   lvl = -LVL_OUTER;
            2'b01:   lvl = -LVL_INNER;
            2'b11:   lvl =  LVL_INNER;
            default: lvl =  LVL_OUTER;
        endcase
        return lvl;
    endfunction

`ifdef LFSR_LOCKUP_DET_EN
    assign lock_hit = (state == S_RUN) && (lfsr_in == '0);
`else
    assign lock_hit = 1'b0;
`endif

    // A lockup cycle is neither a seed match nor a symbol sample: the block
    // is about to reseed and that state carries no valid data.
    assign seed_hit    = (state == S_RUN) && !lock_hit && (lfsr_in == seed_reg);
    // No sample on the cycle stop is seen: its symbol would land in IDLE.
    assign sample_fire = (state == S_RUN) && !stop && !lock_hit && (sample_cnt == '0);

    // Decoded straight from the state register so that an asynchronous reset
    // drops the strobe in the same cycle.
    assign lfsr_load = (state == S_LOAD);
    assign busy      = (state != S_IDLE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of the order blocks are evaluated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_nx is defaulted before the case so every path assigns it and
    // no latch can be inferred.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start && !stop) state_nx = S_LOAD;
            S_LOAD:   state_nx = stop ? S_IDLE : S_SETTLE;
            S_SETTLE: state_nx = stop ? S_IDLE : S_RUN;
            S_RUN: begin
                if (stop) begin
                    state_nx = S_IDLE;
                end else if (lock_hit) begin
                    state_nx = S_LOAD;
                end
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Symbol sampling and period tracking
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_reg   <= '0;
            sample_cnt <= '0;
            cycle_cnt  <= '0;
            sym_out    <= '0;
            sym_valid  <= 1'b0;
            seq_wrap   <= 1'b0;
            period_out <= '0;
        end else begin
            sym_valid <= sample_fire;
            seq_wrap  <= seed_hit;

            if (sample_fire) begin
                sym_out <= map_level(lfsr_in[1:0]);
            end

            if (state == S_SETTLE) begin
                // The LFSR presents the freshly loaded seed in this cycle.
                seed_reg   <= lfsr_in;
                sample_cnt <= '0;
                cycle_cnt  <= CYC_ONE;
            end else if (state == S_RUN) begin
                sample_cnt <= (sample_cnt == SAMPLE_LAST) ? '0 : sample_cnt + 1'b1;
                if (seed_hit) begin
                    period_out <= cycle_cnt;
                    cycle_cnt  <= CYC_ONE;
                end else if (!lock_hit && cycle_cnt != CYC_MAX) begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Lockup flag
    // -------------------------------------------------------------------------
`ifdef LFSR_LOCKUP_DET_EN
    logic lockup_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lockup_q <= 1'b0;
        end else if (lock_hit) begin
            lockup_q <= 1'b1;
        end
    end

    assign lockup = lockup_q;
`else
    assign lockup = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_symbol_mapper.sv
// -----------------------------------------------------------------------------
// tb_lfsr_symbol_mapper
//
// Self-checking bench for lfsr_symbol_mapper. A bench-side LFSR source (real
// x^22+x^21+1 LFSR or a periodic table stub) answers the load strobe. For
// each run the stimulus computes, from the source sequence, which symbols,
// wraps and load strobes must appear and on which cycle, and queues them; a
// separate monitor pops and compares whenever the DUT presents one.
// -----------------------------------------------------------------------------
module tb_lfsr_symbol_mapper;

    localparam int SPS     = 4;
    localparam int A_LEVEL = 32768;
    localparam int OUT_W   = 18;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic                    stop;
    logic [21:0]             lfsr_in = '0;
    logic                    lfsr_load;
    logic signed [OUT_W-1:0] sym_out;
    logic                    sym_valid;
    logic                    busy;
    logic                    seq_wrap;
    logic [22:0]             period_out;
    logic                    lockup;

    lfsr_symbol_mapper #(.SPS(SPS), .A_LEVEL(A_LEVEL), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .lfsr_in(lfsr_in), .lfsr_load(lfsr_load), .sym_out(sym_out),
        .sym_valid(sym_valid), .busy(busy), .seq_wrap(seq_wrap),
        .period_out(period_out), .lockup(lockup)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic signed [63:0] actual,
                         input logic signed [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- source model ----------------
    bit          use_lfsr  = 1'b1;
    logic [21:0] lfsr_seed = 22'h1;
    logic [21:0] tbl [64];
    int          tbl_len   = 1;

    function automatic logic [21:0] lfsr_step(input logic [21:0] s);
        return {s[20:0], s[21] ^ s[20]};
    endfunction

    // Value the source presents 'step' clocks after its seed load.
    function automatic logic [21:0] src_val(input int step);
        logic [21:0] s;
        if (use_lfsr) begin
            s = lfsr_seed;
            for (int i = 0; i < step; i++) s = lfsr_step(s);
        end else begin
            s = tbl[step % tbl_len];
        end
        return s;
    endfunction

    task automatic fill_table(input int p);
        tbl_len = p;
        // bit 21 set only in the seed, bit 20 set in all others: entries are
        // distinct from the seed and never zero.
        tbl[0] = {1'b1, 21'($urandom)};
        for (int i = 1; i < p; i++) tbl[i] = {2'b01, 20'($urandom)};
    endtask

    int src_step = 0;
    always begin : source_stub
        logic ld;
        @(posedge clk);
        ld = lfsr_load;
        #1;
        if (ld) src_step = 0;
        else    src_step++;
        lfsr_in = src_val(src_step);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t sym_q[$];
    exp_t wrap_q[$];
    int   load_q[$];
    int   last_sym = 0;

    function automatic int map_sym(input logic [1:0] b);
        case (b)
            2'b00:   return -3 * A_LEVEL;
            2'b01:   return -A_LEVEL;
            2'b11:   return A_LEVEL;
            default: return 3 * A_LEVEL;
        endcase
    endfunction

    // Start sampled at edge e0: LOAD is cycle e0, SETTLE e0+1, RUN cycle j is
    // e0+2+j and sees source step j+1. Its symbol / wrap shows one cycle later.
    task automatic push_expect(input int e0, input int sym_lim, input int wrap_lim);
        int prev = 0;
        exp_t e;
        load_q.push_back(e0);
        for (int j = 0; j < sym_lim; j++) begin
            if (j % SPS == 0) begin
                e.cyc = e0 + 3 + j;
                e.val = map_sym(src_val(j + 1)[1:0]);
                sym_q.push_back(e);
                last_sym = e.val;
            end
        end
        for (int j = 0; j < wrap_lim; j++) begin
            if (src_val(j + 1) == src_val(0)) begin
                e.cyc = e0 + 3 + j;
                e.val = (j + 1) - prev;
                wrap_q.push_back(e);
                prev = j + 1;
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   c;
        if (reset === 1'b0) begin
            if (lfsr_load) begin
                if (load_q.size() == 0) check("load_unexpected", 1, 0);
                else begin
                    c = load_q.pop_front();
                    check("load_cycle", cyc, c);
                end
            end
            if (sym_valid) begin
                if (sym_q.size() == 0) check("sym_unexpected", 1, 0);
                else begin
                    e = sym_q.pop_front();
                    check("sym_cycle", cyc, e.cyc);
                    check("sym_value", $signed(sym_out), e.val);
                end
            end
            if (seq_wrap) begin
                if (wrap_q.size() == 0) check("wrap_unexpected", 1, 0);
                else begin
                    e = wrap_q.pop_front();
                    check("wrap_cycle", cyc, e.cyc);
                    check("period_out", period_out, e.val);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "_lfsr_load"}, lfsr_load, 0);
        check({tag, "_sym_out"}, $signed(sym_out), 0);
        check({tag, "_sym_valid"}, sym_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_seq_wrap"}, seq_wrap, 0);
        check({tag, "_period_out"}, period_out, 0);
        check({tag, "_lockup"}, lockup, 0);
    endtask

    // Run for m RUN cycles, stop seen in the last one.
    task automatic do_run(input int m, input int prev_period);
        int e0;
        @(negedge clk);
        e0 = cyc + 1;
        push_expect(e0, m - 1, m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run_busy", busy, 1);
        check("period_kept", period_out, prev_period);
        while (cyc < e0 + 1 + m) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_valid", sym_valid, 0);
        repeat (3) @(negedge clk);
        check("sym_hold", $signed(sym_out), last_sym);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int e0;
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;

        repeat (21) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Real LFSR source, random non-zero seed.
        use_lfsr  = 1'b1;
        lfsr_seed = {1'b1, 21'($urandom)};
        do_run(30, 0);

        // Periodic stub, period 10, Gray patterns at the first four samples.
        use_lfsr = 1'b0;
        fill_table(10);
        tbl[1][1:0] = 2'b00;
        tbl[5][1:0] = 2'b01;
        tbl[9][1:0] = 2'b11;
        tbl[3][1:0] = 2'b10;
        do_run(35, 0);

        // start and stop together in IDLE: nothing happens.
        start = 1'b1;
        stop  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("both_busy", busy, 0);
            check("both_load", lfsr_load, 0);
        end
        start = 1'b0;
        stop  = 1'b0;

        // Period survives stop/start.
        use_lfsr  = 1'b1;
        lfsr_seed = {1'b1, 21'($urandom)};
        do_run(21, 10);

        // Asynchronous reset while in LOAD.
        @(negedge clk);
        e0 = cyc + 1;
        load_q.push_back(e0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_load_drop", lfsr_load, 0);
        check("rst_load_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset mid-RUN while sym_valid is high.
        use_lfsr = 1'b0;
        fill_table(10);
        @(negedge clk);
        e0 = cyc + 1;
        push_expect(e0, 13, 13);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e0 + 15) @(negedge clk);
        check("pre_rst_valid", sym_valid, 1);
        check("pre_rst_period", period_out, 10);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Restart after reset, period 7.
        fill_table(7);
        do_run(40, 0);

        // All-zero LFSR state at step 9 (a sample point).
        fill_table(20);
        tbl[9] = '0;
`ifdef LFSR_LOCKUP_DET_EN
        @(negedge clk);
        e0 = cyc + 1;
        push_expect(e0, 8, 8);
        load_q.push_back(e0 + 11);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e0 + 11) @(negedge clk);
        check("lockup_set", lockup, 1);
        check("lockup_reload", lfsr_load, 1);
        check("lockup_no_valid", sym_valid, 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("lockup_stop_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("lockup_sticky", lockup, 1);
`else
        do_run(25, 7);
        check("lockup_tied", lockup, 0);
`endif

        // Final reset clears sticky and period state.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_all_zero("final_rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        check("sym_q_drained", sym_q.size(), 0);
        check("wrap_q_drained", wrap_q.size(), 0);
        check("load_q_drained", load_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
